clk_sel_tx: RTL and testbench
=============================

# clk_sel_tx

Serial transmitter for clock-select commands. It accepts a parallel request (master select plus 3-bit design-clock select) over a valid/ready handshake. It emits the request as a framed, bit-timed serial stream on `DATA_OUT`, with a mid-bit `STROBE_OUT`. It sits on the control side of the clock-trial fabric and drives the serial `DATA_IN` of the clock-select shift-register receiver.

## Interface
Parameters:
- `BIT_CYCLES`, default 4: CLK cycles per serial bit; legal range 2..255.
- `GAP_BITS`, default 2: idle bit periods (line low) appended after each frame; legal range 0..15.

Ports:
- `CLK` in 1: clock.
- `RESETn` in 1: reset, asynchronous, active-low.
- `REQ_VALID` in 1: request valid.
- `REQ_READY` out 1: block can accept a request.
- `REQ_MASTER_SEL` in 1: master clock select payload bit.
- `REQ_DESIGN_SEL` in 3: design clock select payload.
- `DATA_OUT` out 1: serial line. Idles low.
- `STROBE_OUT` out 1: one-cycle pulse at the middle of each transmitted frame bit.
- `BUSY` out 1: a frame or its gap is in progress.
- `DONE` out 1: one-cycle pulse when a frame, including its gap, completes.

## Operation
- Frame, in transmit order:
  - Start bit, value 1.
  - `REQ_DESIGN_SEL[0]`, `[1]`, `[2]`.
  - `REQ_MASTER_SEL`.
  - Parity bit, only when configured.
  - `GAP_BITS` periods of 0.
- FSM states: IDLE → START → DATA (4 bits, index 0..3) → PARITY (only when configured) → GAP (skipped when `GAP_BITS`=0) → IDLE.
- IDLE:
  - `REQ_READY`=1.
  - A handshake occurs when `REQ_VALID`&`REQ_READY` are both high at a CLK edge.
  - On a handshake, capture the payload into a 4-bit shift register and go to START.
  - `REQ_VALID` without `REQ_READY` is ignored. The requester holds the request.
- Payload is captured only at the handshake. Input changes during a frame have no effect.
- Each bit lasts exactly `BIT_CYCLES` cycles. A cycle counter runs from 0 to `BIT_CYCLES`-1, then the next bit starts.
- `STROBE_OUT` pulses when the cycle counter equals `BIT_CYCLES`/2 (integer division). It pulses during START, DATA and PARITY only, never during GAP or IDLE.
- Bit-index counter: 2 bits wide. Leave DATA after index 3; never wrap.
- Gap counter: 4 bits wide. Counts bit periods 0..`GAP_BITS`-1.
- `BUSY`=1 in every state except IDLE.
- `DONE` pulses in the last cycle of the final frame period, coincident with the transition to IDLE.
- Reset, including mid-frame:
  - All state clears immediately.
  - `DATA_OUT`=0, `STROBE_OUT`=0, `BUSY`=0, `DONE`=0, `REQ_READY`=0.
  - The partial frame is abandoned, not resumed.

## Timing
- All outputs are registered.
- Reset values: every output is 0.
- `REQ_READY` rises at the first CLK edge after `RESETn` deasserts.
- Handshake at edge N:
  - `REQ_READY` falls, `BUSY` rises and `DATA_OUT`=1 (start bit), all from edge N.
  - The start bit holds for cycles N..N+`BIT_CYCLES`-1.
- Frame bits F = 5, or 6 with parity.
- Total busy time T = (F+`GAP_BITS`)×`BIT_CYCLES` cycles.
- Completion:
  - `DONE`=1 in cycle N+T-1.
  - `REQ_READY`=1 and `BUSY`=0 from edge N+T.
- Back-to-back: a new handshake is possible at edge N+T. Its start bit follows the gap with no extra idle cycle.
- `STROBE_OUT` for bit k (k=0 is start) is high in cycle N+k×`BIT_CYCLES`+`BIT_CYCLES`/2.

## Configuration
- Macro: `CLK_SEL_TX_PARITY_EN`.
- Defined:
  - PARITY state is present; F=6.
  - The parity bit is even parity over the 4 payload bits, i.e. the XOR of `REQ_DESIGN_SEL[2:0]` and `REQ_MASTER_SEL`.
  - The parity bit gets a `STROBE_OUT` pulse.
- Undefined:
  - PARITY state and XOR logic are absent; F=5.
  - DATA goes directly to GAP, or to IDLE when `GAP_BITS`=0.

## Structure
- Shared package `clk_sel_pkg` holds:
  - FSM state enum.
  - `CLK_SEL_PAYLOAD_BITS`=4.
  - `CLK_SEL_START_LEVEL`=1'b1.
  - `CLK_SEL_IDLE_LEVEL`=1'b0.
  - The receiver uses the same constants.
- Sub-module `clk_sel_bit_timer`:
  - Contains the `BIT_CYCLES` counter.
  - Outputs `bit_end` and `bit_mid` pulses.
  - Has a synchronous `restart` input, asserted on handshake.

## Test plan
All scenarios use `BIT_CYCLES`=4, `GAP_BITS`=2, parity enabled.
- Reset release → `REQ_READY` 0 during reset, 1 one cycle after release; `DATA_OUT`=0.
- `REQ_MASTER_SEL`=1, `REQ_DESIGN_SEL`=3'b101 → `DATA_OUT` bits 1,1,0,1,1, parity 1, then 0,0, each held 4 cycles. 6 `STROBE_OUT` pulses at offsets 2,6,10,14,18,22. `DONE` at cycle 31. `REQ_READY` again at 32.
- `REQ_VALID` held high with a new payload (0, 3'b010) → the second frame's start bit begins exactly at cycle 32. Parity bit = 1.
- Payload inputs toggled every cycle mid-frame → transmitted bits match the values captured at the handshake.
- `RESETn` pulsed low during DATA bit 2 → all outputs 0 immediately; no `DONE`; the next request transmits a complete, correct frame.
- Build without `CLK_SEL_TX_PARITY_EN` → 5 frame bits, 5 strobes, busy 28 cycles.

Source files
------------

// File: rtl/clk_sel_pkg.sv
// clk_sel_pkg: constants and FSM state type shared by the clock-select transmitter and receiver.
// Rev 1.0
`default_nettype none

package clk_sel_pkg;

   localparam int   CLK_SEL_PAYLOAD_BITS = 4;
   localparam logic CLK_SEL_START_LEVEL  = 1'b1;
   localparam logic CLK_SEL_IDLE_LEVEL   = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_GAP    = 3'd4
   } clk_sel_state_e;

endpackage

`default_nettype wire

// File: rtl/clk_sel_bit_timer.sv
// clk_sel_bit_timer: BIT_CYCLES cycle counter with bit-end and look-ahead mid/pre-end pulses.
// Rev 1.0
`default_nettype none

module clk_sel_bit_timer #(
   parameter int BIT_CYCLES = 4
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic restart_i,
   output logic bit_end_o,
   output logic bit_mid_o,
   output logic bit_pre_end_o
);

   localparam logic [7:0] C_LAST    = 8'(BIT_CYCLES - 1);
   localparam logic [7:0] C_MID_PRE = 8'(BIT_CYCLES / 2 - 1);
   localparam logic [7:0] C_PRE_END = 8'(BIT_CYCLES - 2);

   logic [7:0] cnt_q;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt_q <= 8'd0;
      end else if (restart_i || (cnt_q == C_LAST)) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   // Mid and pre-end fire one cycle early so registered consumers land on the exact cycle.
   assign bit_end_o     = (cnt_q == C_LAST);
   assign bit_mid_o     = (cnt_q == C_MID_PRE);
   assign bit_pre_end_o = (cnt_q == C_PRE_END);

endmodule

`default_nettype wire

// File: rtl/clk_sel_tx.sv
// clk_sel_tx: framed, bit-timed serial transmitter for clock-select requests.
// Rev 1.0 -- optional even-parity bit enabled by defining CLK_SEL_TX_PARITY_EN.
`default_nettype none

module clk_sel_tx
   import clk_sel_pkg::*;
#(
   parameter int BIT_CYCLES = 4,
   parameter int GAP_BITS   = 2
) (
   input  logic       CLK,
   input  logic       RESETn,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic       REQ_MASTER_SEL,
   input  logic [2:0] REQ_DESIGN_SEL,
   output logic       DATA_OUT,
   output logic       STROBE_OUT,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [3:0] C_GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

   clk_sel_state_e                  state_q;
   logic [CLK_SEL_PAYLOAD_BITS-1:0] sr_q;
   logic [1:0]                      idx_q;
   logic [3:0]                      gap_q;
   logic                            data_q, strobe_q, busy_q, done_q, ready_q;
`ifdef CLK_SEL_TX_PARITY_EN
   logic                            par_q;
`endif

   logic bit_end, bit_mid, bit_pre_end;
   logic tx_last, last_period, accept;

`ifdef CLK_SEL_TX_PARITY_EN
   assign tx_last = (state_q == ST_PARITY);
`else
   assign tx_last = (state_q == ST_DATA) && (idx_q == 2'd3);
`endif
   assign last_period = (GAP_BITS == 0) ? tx_last
                                        : ((state_q == ST_GAP) && (gap_q == C_GAP_LAST));

   // A request waiting at the end of a frame is taken in the frame's last cycle for back-to-back.
   assign accept = REQ_VALID && (ready_q || (bit_end && last_period));

   clk_sel_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .CLK           (CLK),
      .RESETn        (RESETn),
      .restart_i     (accept),
      .bit_end_o     (bit_end),
      .bit_mid_o     (bit_mid),
      .bit_pre_end_o (bit_pre_end)
   );

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= ST_IDLE;
         sr_q     <= '0;
         idx_q    <= 2'd0;
         gap_q    <= 4'd0;
         data_q   <= CLK_SEL_IDLE_LEVEL;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b0;
`ifdef CLK_SEL_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         strobe_q <= bit_mid && ((state_q == ST_START) || (state_q == ST_DATA) ||
                                 (state_q == ST_PARITY));
         done_q   <= bit_pre_end && last_period;
         if (accept) begin
            state_q <= ST_START;
            sr_q    <= {REQ_MASTER_SEL, REQ_DESIGN_SEL};
            idx_q   <= 2'd0;
            gap_q   <= 4'd0;
            data_q  <= CLK_SEL_START_LEVEL;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
`ifdef CLK_SEL_TX_PARITY_EN
            par_q   <= ^{REQ_MASTER_SEL, REQ_DESIGN_SEL};
`endif
         end else if (bit_end && last_period) begin
            state_q <= ST_IDLE;
            data_q  <= CLK_SEL_IDLE_LEVEL;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
         end else if (bit_end) begin
            case (state_q)
               ST_START, ST_DATA: begin
                  if ((state_q == ST_DATA) && (idx_q == 2'd3)) begin
`ifdef CLK_SEL_TX_PARITY_EN
                     state_q <= ST_PARITY;
                     data_q  <= par_q;
`else
                     state_q <= ST_GAP;
                     data_q  <= CLK_SEL_IDLE_LEVEL;
`endif
                  end else begin
                     state_q <= ST_DATA;
                     idx_q   <= (state_q == ST_START) ? 2'd0 : idx_q + 2'd1;
                     data_q  <= sr_q[0];
                     sr_q    <= {1'b0, sr_q[CLK_SEL_PAYLOAD_BITS-1:1]};
                  end
               end
               ST_PARITY: begin
                  state_q <= ST_GAP;
                  data_q  <= CLK_SEL_IDLE_LEVEL;
               end
               ST_GAP: begin
                  gap_q <= gap_q + 4'd1;
               end
               default: begin
                  ready_q <= 1'b1;
               end
            endcase
         end else if (state_q == ST_IDLE) begin
            ready_q <= 1'b1;
         end
      end
   end

   assign DATA_OUT   = data_q;
   assign STROBE_OUT = strobe_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign REQ_READY  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_sel_tx.sv
// tb_clk_sel_tx: self-checking bench for clk_sel_tx (table vectors, random frames, reset corner cases).
// Rev 1.0
`default_nettype none

module tb_clk_sel_tx;

   localparam int BC = 4;
   localparam int GB = 2;
`ifdef CLK_SEL_TX_PARITY_EN
   localparam int F = 6;
`else
   localparam int F = 5;
`endif
   localparam int T = (F + GB) * BC;

   logic       CLK = 1'b0;
   logic       RESETn;
   logic       REQ_VALID;
   logic       REQ_READY;
   logic       REQ_MASTER_SEL;
   logic [2:0] REQ_DESIGN_SEL;
   logic       DATA_OUT, STROBE_OUT, BUSY, DONE;
   logic [4:0] outs;

   int n_checks = 0;
   int n_fail   = 0;

   clk_sel_tx #(.BIT_CYCLES(BC), .GAP_BITS(GB)) dut (
      .CLK            (CLK),
      .RESETn         (RESETn),
      .REQ_VALID      (REQ_VALID),
      .REQ_READY      (REQ_READY),
      .REQ_MASTER_SEL (REQ_MASTER_SEL),
      .REQ_DESIGN_SEL (REQ_DESIGN_SEL),
      .DATA_OUT       (DATA_OUT),
      .STROBE_OUT     (STROBE_OUT),
      .BUSY           (BUSY),
      .DONE           (DONE)
   );

   always #5 CLK = ~CLK;

   // {ready, busy, data, strobe, done}
   assign outs = {REQ_READY, BUSY, DATA_OUT, STROBE_OUT, DONE};

   typedef struct {
      logic       m;
      logic [2:0] ds;
      logic [5:0] exp_bits;   // bit k = frame bit k (0 = start, 5 = parity)
      bit         chain;      // hold REQ_VALID so the next entry follows back-to-back
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Frame bits straight from the frame definition: start, dsel[0..2], master, even parity.
   function automatic logic [5:0] model_bits(input logic m, input logic [2:0] ds);
      int ones;
      ones = int'(m) + int'(ds[0]) + int'(ds[1]) + int'(ds[2]);
      return {(ones % 2) == 1, m, ds, 1'b1};
   endfunction

   task automatic handshake(input logic m, input logic [2:0] ds);
      int w;
      w = 0;
      while (!REQ_READY && w < 100) begin
         step();
         w++;
      end
      chk("ready_wait", 5'(REQ_READY), 5'd1);
      REQ_VALID      = 1'b1;
      REQ_MASTER_SEL = m;
      REQ_DESIGN_SEL = ds;
      step();
   endtask

   // Called in cycle N (handshake just taken); checks every cycle of the frame and its gap.
   task automatic play(input logic [5:0] bits, input bit chain, input logic nm, input logic [2:0] nds);
      int strobes, dones, k, ph;
      logic [4:0] e;
      strobes = 0;
      dones   = 0;
      for (int t = 0; t < T; t++) begin
         k  = t / BC;
         ph = t % BC;
         e  = {1'b0, 1'b1, (k < F) ? bits[k] : 1'b0, (k < F) && (ph == BC / 2), t == T - 1};
         chk("frame_cycle", outs, e);
         strobes += int'(STROBE_OUT);
         dones   += int'(DONE);
         if (t < T - 1) begin
            REQ_VALID      = 1'($urandom_range(0, 1));
            REQ_MASTER_SEL = 1'($urandom_range(0, 1));
            REQ_DESIGN_SEL = 3'($urandom_range(0, 7));
         end else if (chain) begin
            REQ_VALID      = 1'b1;
            REQ_MASTER_SEL = nm;
            REQ_DESIGN_SEL = nds;
         end else begin
            REQ_VALID = 1'b0;
         end
         step();
      end
      chk("strobe_count", 5'(strobes), 5'(F));
      chk("done_count", 5'(dones), 5'd1);
      if (!chain) chk("idle_after_frame", outs, 5'b10000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       cm, nm;
      logic [2:0] cds, nds;
      bit         ch, prev_ch;

      vecs[0] = '{1'b1, 3'b101, 6'b111011, 1'b1};
      vecs[1] = '{1'b0, 3'b010, 6'b100101, 1'b0};
      vecs[2] = '{1'b0, 3'b000, 6'b000001, 1'b0};
      vecs[3] = '{1'b1, 3'b111, 6'b011111, 1'b1};
      vecs[4] = '{1'b0, 3'b100, 6'b101001, 1'b1};
      vecs[5] = '{1'b1, 3'b011, 6'b110111, 1'b0};

      RESETn         = 1'b0;
      REQ_VALID      = 1'b0;
      REQ_MASTER_SEL = 1'b0;
      REQ_DESIGN_SEL = 3'd0;
      repeat (3) begin
         step();
         chk("reset_outputs", outs, 5'b00000);
      end
      RESETn = 1'b1;
      #1;
      chk("ready_before_edge", outs, 5'b00000);
      step();
      chk("reset_release", outs, 5'b10000);

      prev_ch = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (!prev_ch) handshake(vecs[i].m, vecs[i].ds);
         play(vecs[i].exp_bits, vecs[i].chain,
              (i < 5) ? vecs[(i + 1) % 6].m  : 1'b0,
              (i < 5) ? vecs[(i + 1) % 6].ds : 3'd0);
         prev_ch = vecs[i].chain;
      end

      cm      = 1'($urandom_range(0, 1));
      cds     = 3'($urandom_range(0, 7));
      prev_ch = 1'b0;
      for (int r = 0; r < 10; r++) begin
         ch  = (r < 9) && ($urandom_range(0, 1) == 1);
         nm  = 1'($urandom_range(0, 1));
         nds = 3'($urandom_range(0, 7));
         if (!prev_ch) handshake(cm, cds);
         play(model_bits(cm, cds), ch, nm, nds);
         cm      = nm;
         cds     = nds;
         prev_ch = ch;
      end

      // Reset in the middle of DATA bit 2, then a clean frame afterwards.
      handshake(1'b1, 3'b110);
      REQ_VALID = 1'b0;
      repeat (13) step();
      chk("pre_reset_data", 5'(DATA_OUT), 5'd1);
      RESETn = 1'b0;
      #1;
      chk("async_reset_outputs", outs, 5'b00000);
      repeat (3) begin
         step();
         chk("held_reset_outputs", outs, 5'b00000);
      end
      RESETn = 1'b1;
      step();
      chk("mid_reset_release", outs, 5'b10000);
      repeat (2) begin
         step();
         chk("no_resume_after_reset", outs, 5'b10000);
      end
      handshake(1'b0, 3'b011);
      play(model_bits(1'b0, 3'b011), 1'b0, 1'b0, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
